// File: rtl/btn_ctl_if.sv
// rtl/btn_ctl_if.sv - button control bus: raw buttons in, one-hot control code and debounced levels out
interface btn_ctl_if;
    logic [2:0] btn_raw;
    logic [2:0] ctl;
    logic [2:0] btn_lvl;

    // Master drives the raw buttons and observes the conditioned outputs.
    modport master (
        output btn_raw,
        input  ctl,
        input  btn_lvl
    );

    // Slave is the conditioning block itself.
    modport slave (
        input  btn_raw,
        output ctl,
        output btn_lvl
    );
endinterface

// File: rtl/btn_ctl.sv
// rtl/btn_ctl.sv - button synchronizer, debouncer, one-pulse and one-hot arbiter; optional BTN_AUTOREPEAT_EN
module btn_ctl #(
    parameter int SAMPLE_DIV  = 100000,
    parameter int DEB_SAMPLES = 8,
    parameter int REP_DELAY   = 500,
    parameter int REP_PERIOD  = 200
) (
    input  logic      clk,
    input  logic      rst_n,
    btn_ctl_if.slave  bus
);
    localparam int               DIV_W        = $clog2(SAMPLE_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [7:0]       DEB_LAST     = 8'(DEB_SAMPLES - 1);
    localparam logic [15:0]      REP_DELAY_C  = 16'(REP_DELAY);
    localparam logic [15:0]      REP_PERIOD_C = 16'(REP_PERIOD);

    typedef enum logic [1:0] {S_IDLE, S_PULSE, S_GAP} state_t;

    logic [2:0]       sync1_q, sync2_q;
    logic [DIV_W-1:0] div_q;
    logic             tick;
    logic [2:0][7:0]  deb_cnt_q, deb_cnt_d;
    logic [2:0]       lvl_q, lvl_d;
    logic [2:0]       pend_q, pend_d, pend_clr, rep_set;
    state_t           state_q, state_d;
    logic [2:0]       ctl_q, ctl_d;

    // Two-flop synchronizer for the asynchronous button inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 3'b000;
            sync2_q <= 3'b000;
        end else begin
            sync1_q <= bus.btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // Free-running sample divider producing a one-cycle debounce tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else if (tick) begin
            div_q <= '0;
        end else begin
            div_q <= div_q + 1'b1;
        end
    end

    assign tick = (div_q == DIV_LAST);

    // Debounce: a level flips only after DEB_SAMPLES consecutive disagreeing ticks.
    always_comb begin
        lvl_d     = lvl_q;
        deb_cnt_d = deb_cnt_q;
        for (int i = 0; i < 3; i++) begin
            if (tick) begin
                if (sync2_q[i] == lvl_q[i]) begin
                    deb_cnt_d[i] = 8'd0;
                end else if (deb_cnt_q[i] == DEB_LAST) begin
                    lvl_d[i]     = sync2_q[i];
                    deb_cnt_d[i] = 8'd0;
                end else begin
                    deb_cnt_d[i] = deb_cnt_q[i] + 8'd1;
                end
            end
        end
    end

    // Debounced level and per-bit disagreement counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_q     <= 3'b000;
            deb_cnt_q <= '0;
        end else begin
            lvl_q     <= lvl_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    logic [2:0][15:0] rep_cnt_q, rep_cnt_d;
    logic [2:0]       rep_armed_q, rep_armed_d;

    // Repeat timer: first request after REP_DELAY ticks held, then every REP_PERIOD ticks.
    // Gated by lvl_d so the tick that releases the button cannot raise a late request.
    always_comb begin
        rep_cnt_d   = rep_cnt_q;
        rep_armed_d = rep_armed_q;
        rep_set     = 3'b000;
        for (int i = 0; i < 3; i++) begin
            if (!lvl_q[i]) begin
                rep_cnt_d[i]   = 16'd0;
                rep_armed_d[i] = 1'b0;
            end else if (tick && lvl_d[i]) begin
                if ((rep_cnt_q[i] + 16'd1) == (rep_armed_q[i] ? REP_PERIOD_C : REP_DELAY_C)) begin
                    rep_set[i]     = 1'b1;
                    rep_cnt_d[i]   = 16'd0;
                    rep_armed_d[i] = 1'b1;
                end else begin
                    rep_cnt_d[i] = rep_cnt_q[i] + 16'd1;
                end
            end
        end
    end

    // Repeat timer state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rep_cnt_q   <= '0;
            rep_armed_q <= 3'b000;
        end else begin
            rep_cnt_q   <= rep_cnt_d;
            rep_armed_q <= rep_armed_d;
        end
    end
`else
    logic unused_rep;
    assign unused_rep = ^{REP_DELAY_C, REP_PERIOD_C};
    assign rep_set    = 3'b000;
`endif

    // Pending requests: a new set wins over a same-cycle clear so no press is lost.
    assign pend_d = (pend_q & ~pend_clr) | (lvl_d & ~lvl_q) | rep_set;

    // Arbiter next state: one-cycle code, then two guaranteed zero cycles.
    always_comb begin
        state_d  = state_q;
        ctl_d    = 3'b000;
        pend_clr = 3'b000;
        case (state_q)
            S_IDLE: begin
                if (pend_q[0]) begin
                    ctl_d    = 3'b001;
                    pend_clr = 3'b001;
                    state_d  = S_PULSE;
                end else if (pend_q[1]) begin
                    ctl_d    = 3'b010;
                    pend_clr = 3'b010;
                    state_d  = S_PULSE;
                end else if (pend_q[2]) begin
                    ctl_d    = 3'b100;
                    pend_clr = 3'b100;
                    state_d  = S_PULSE;
                end
            end
            S_PULSE: state_d = S_GAP;
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Arbiter state, pending flags and registered control code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pend_q  <= 3'b000;
            ctl_q   <= 3'b000;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ctl_q   <= ctl_d;
        end
    end

    assign bus.ctl     = ctl_q;
    assign bus.btn_lvl = lvl_q;
endmodule

// File: doc/btn_ctl.md
Name: btn_ctl

Overview:
- Front end of the clock/date display control path: conditions three raw push-buttons into the 3-bit one-hot control code that the display-mode FSM samples every clock.
- Per button: 2-flop synchronizer, tick-based debouncer and rising-edge one-pulse.
- An output arbiter guarantees the FSM only ever sees 3'b000, 3'b001, 3'b010 or 3'b100, each code lasting exactly one clock.

Parameters:
SAMPLE_DIV, 100000, clk cycles per debounce sample tick (1 ms at 100 MHz); legal range >= 2
DEB_SAMPLES, 8, consecutive differing ticks needed to flip a debounced level; legal range 1..255
REP_DELAY, 500, ticks held before the first auto-repeat (only with BTN_AUTOREPEAT_EN)
REP_PERIOD, 200, ticks between later auto-repeats (only with BTN_AUTOREPEAT_EN)

Ports:
clk      input   1  crystal clock
rst_n    input   1  asynchronous active-low reset
btn_raw  input   3  raw buttons, active-high, asynchronous to clk; bit0 = sec/toggle, bit1 = 12/24, bit2 = date
ctl      output  3  registered one-hot control pulse, connected to the display FSM `in`
btn_lvl  output  3  debounced button levels, registered

Behaviour:
Reset (asynchronous, rst_n = 0):
- All registers clear.
- ctl = 3'b000, btn_lvl = 3'b000, tick counter = 0, pending = 0, arbiter in IDLE.
Synchronizer:
- btn_raw passes through 2 flops per bit, giving sync[2:0].
Tick counter:
- Counts 0..SAMPLE_DIV-1 and wraps to 0.
- tick = 1 for one cycle when the count equals SAMPLE_DIV-1.
Debouncer, per bit i, evaluated only on tick:
- sync[i] == btn_lvl[i]: deb_cnt[i] <= 0.
- sync[i] != btn_lvl[i] and deb_cnt[i] == DEB_SAMPLES-1: btn_lvl[i] <= sync[i], deb_cnt[i] <= 0.
- Otherwise deb_cnt[i] increments.
- Any glitch shorter than DEB_SAMPLES ticks is rejected; the counter restarts after each disagreement.
One-pulse:
- pending[i] is set on the same edge where btn_lvl[i] goes 0->1.
- A release (1->0) never sets pending.
Arbiter FSM:
- States are IDLE, PULSE, GAP.
- IDLE: if pending != 0, pick the lowest-index set bit k, set ctl <= (1<<k), clear pending[k], go to PULSE. Otherwise ctl <= 000.
- PULSE: ctl <= 000, go to GAP.
- GAP: ctl <= 000, go to IDLE.
- Net effect: every code is 1 cycle wide, with >= 2 zero cycles between codes.
- Latency from the btn_lvl rise edge to ctl assertion is 1 cycle when IDLE with no other pending request.
Simultaneous events:
- Several bits rising together are all latched into pending.
- They are emitted in order bit0, bit1, bit2, one per 3-cycle slot. None is lost.
- A new rise on a bit whose pending flag is already set merges into that flag; one pulse is emitted.
Reset mid-operation:
- Pending requests are discarded.
- A button held through reset release is seen as a fresh press: one pulse after DEB_SAMPLES ticks.
Invariants:
- ctl is never multi-hot.
- ctl never holds a nonzero value for two consecutive cycles.

Optional Feature:
BTN_AUTOREPEAT_EN
- Defined:
  - Each bit has a repeat tick counter, cleared whenever btn_lvl[i] == 0.
  - While btn_lvl[i] == 1, the counter reaches REP_DELAY ticks and sets pending[i], then reloads.
  - After that, pending[i] is set again every REP_PERIOD ticks.
  - Releasing the button stops repeats immediately; an already-set pending flag is still emitted.
- Undefined:
  - No repeat counters are built.
  - A held button yields exactly one pulse; REP_DELAY and REP_PERIOD are unused.

Test Plan:
1. SAMPLE_DIV=4, DEB_SAMPLES=3; hold btn_raw=3'b010 for 40 cycles -> btn_lvl[1] rises once; ctl=3'b010 for exactly 1 cycle, 1 cycle after that rise; ctl=000 otherwise.
2. Same parameters; btn_raw[0] pulses high for 6 cycles (under 3 ticks) -> btn_lvl stays 000 and ctl stays 000 throughout.
3. btn_raw 000 -> 111 in one cycle, held -> ctl sequence 001, 000, 000, 010, 000, 000, 100, then 000; never multi-hot.
4. Hold btn_raw=3'b100, pulse rst_n low for 2 cycles mid-hold -> ctl=000 and btn_lvl=000 immediately on reset; after release, exactly one 3'b100 pulse follows 3 ticks later.
5. Press then release btn_raw[2] with a stable 40-cycle high and 40-cycle low -> exactly one ctl=3'b100 pulse, none on release.
6. BTN_AUTOREPEAT_EN, REP_DELAY=5, REP_PERIOD=2, hold btn_raw[1] for 20 ticks -> ctl=010 pulses at press, then at +5 ticks, then every 2 ticks; pulses stop within 1 tick of release.
